// File: rtl/dram_cmd_scheduler.sv
// Closed-page DRAM command sequencer: ACT -> RD/WR -> PRE per request, gated by init_valid.
// Build option DRAM_SCHED_REFRESH_EN adds the periodic REF generator, ref_pending and ref_overflow.
module dram_cmd_scheduler #(
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 17,
  parameter int T_RCD  = 16,
  parameter int T_RTP  = 8,
  parameter int T_WTP  = 24,
  parameter int T_RP   = 16,
  parameter int T_RFC  = 350,
  parameter int T_REFI = 3120
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              init_valid,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [1:0]        req_bg,
  input  logic [1:0]        req_ba,
  input  logic [ADDR_W-1:0] req_row,
  input  logic [9:0]        req_col,
  output logic [2:0]        cmd,
  output logic [1:0]        cmd_bg,
  output logic [1:0]        cmd_ba,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic              busy,
  output logic              ref_overflow
);

  typedef enum logic [3:0] {
    WAIT_INIT, IDLE, ACTIVATE, ACT_WAIT, RW_CMD, RW_WAIT,
    PRECHARGE, PRE_WAIT, REFRESH, REF_WAIT
  } state_t;

  localparam logic [2:0] C_NOP = 3'd0, C_ACT = 3'd1, C_RD = 3'd2,
                         C_WR  = 3'd3, C_PRE = 3'd4, C_REF = 3'd5;

  // A wait state lasts gap-1 cycles, so it ends when the count reaches gap-2.
  localparam logic [CNT_W-1:0] RCD_END = CNT_W'(T_RCD - 2);
  localparam logic [CNT_W-1:0] RTP_END = CNT_W'(T_RTP - 2);
  localparam logic [CNT_W-1:0] WTP_END = CNT_W'(T_WTP - 2);
  localparam logic [CNT_W-1:0] RP_END  = CNT_W'(T_RP - 2);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              lat_wr;
  logic [1:0]        lat_bg, lat_ba;
  logic [ADDR_W-1:0] lat_row;
  logic [9:0]        lat_col;
  logic              ref_pending;
  logic              handshake;
  logic [CNT_W-1:0]  rw_end;

  assign req_ready = (state == IDLE) && !ref_pending;
  assign handshake = req_valid && req_ready;
  assign busy      = (state != IDLE);
  assign rw_end    = lat_wr ? WTP_END : RTP_END;

  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= WAIT_INIT;
    else     state <= state_nxt;

  // A gap of 1 has no wait cycles, so the command state hops straight on.
  always_comb begin
    state_nxt = state;
    case (state)
      WAIT_INIT: if (init_valid) state_nxt = IDLE;
      IDLE: begin
`ifdef DRAM_SCHED_REFRESH_EN
        if (ref_pending)    state_nxt = REFRESH;
        else
`endif
        if (handshake)      state_nxt = ACTIVATE;
      end
      ACTIVATE:  state_nxt = (T_RCD > 1) ? ACT_WAIT : RW_CMD;
      ACT_WAIT:  if (cnt == RCD_END) state_nxt = RW_CMD;
      RW_CMD:    state_nxt = (((lat_wr ? T_WTP : T_RTP)) > 1) ? RW_WAIT : PRECHARGE;
      RW_WAIT:   if (cnt == rw_end) state_nxt = PRECHARGE;
      PRECHARGE: state_nxt = (T_RP > 1) ? PRE_WAIT : IDLE;
      PRE_WAIT:  if (cnt == RP_END) state_nxt = IDLE;
`ifdef DRAM_SCHED_REFRESH_EN
      REFRESH:   state_nxt = (T_RFC > 1) ? REF_WAIT : IDLE;
      REF_WAIT:  if (cnt == CNT_W'(T_RFC - 2)) state_nxt = IDLE;
`endif
      default:   state_nxt = WAIT_INIT;
    endcase
  end

  always_comb begin
    cmd      = C_NOP;
    cmd_bg   = '0;
    cmd_ba   = '0;
    cmd_addr = '0;
    case (state)
      ACTIVATE: begin
        cmd      = C_ACT;
        cmd_bg   = lat_bg;
        cmd_ba   = lat_ba;
        cmd_addr = lat_row;
      end
      RW_CMD: begin
        cmd      = lat_wr ? C_WR : C_RD;
        cmd_bg   = lat_bg;
        cmd_ba   = lat_ba;
        cmd_addr = ADDR_W'(lat_col);
      end
      PRECHARGE: begin
        cmd    = C_PRE;
        cmd_bg = lat_bg;
        cmd_ba = lat_ba;
      end
`ifdef DRAM_SCHED_REFRESH_EN
      REFRESH: cmd = C_REF;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else if (state inside {ACT_WAIT, RW_WAIT, PRE_WAIT, REF_WAIT}) cnt <= cnt + CNT_W'(1);
    else cnt <= '0;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      lat_wr  <= 1'b0;
      lat_bg  <= '0;
      lat_ba  <= '0;
      lat_row <= '0;
      lat_col <= '0;
    end else if (handshake) begin
      lat_wr  <= req_wr;
      lat_bg  <= req_bg;
      lat_ba  <= req_ba;
      lat_row <= req_row;
      lat_col <= req_col;
    end

`ifdef DRAM_SCHED_REFRESH_EN
  localparam int RT_W = $clog2(T_REFI);

  logic [RT_W-1:0] ref_timer;
  logic            ref_ovf;

  // The interval clock free-runs from the first IDLE; a wrap with a REF still owed is an overflow.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      ref_timer   <= '0;
      ref_pending <= 1'b0;
      ref_ovf     <= 1'b0;
    end else if (state != WAIT_INIT) begin
      if (ref_timer == RT_W'(T_REFI - 1)) begin
        ref_timer   <= '0;
        ref_pending <= 1'b1;
        if (ref_pending) ref_ovf <= 1'b1;
      end else begin
        ref_timer <= ref_timer + RT_W'(1);
        if (state == REFRESH) ref_pending <= 1'b0;
      end
    end

  assign ref_overflow = ref_ovf;
`else
  assign ref_pending  = 1'b0;
  assign ref_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// Bench for dram_cmd_scheduler: directed vector table, reset/refresh corner sequences and a
// randomized run checked against a timestamp-based schedule model.
module tb_dram_cmd_scheduler;
  localparam int AW = 17;
  localparam int T_RCD = 16, T_RTP = 8, T_WTP = 24, T_RP = 16, T_RFC = 350, T_REFI = 3120;
`ifdef DRAM_SCHED_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic          CLK = 1'b0, RST = 1'b0;
  logic          init_valid = 1'b0, req_valid = 1'b0, req_wr = 1'b0;
  logic [1:0]    req_bg = '0, req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [9:0]    req_col = '0;
  logic          req_ready, busy, ref_overflow;
  logic [2:0]    cmd;
  logic [1:0]    cmd_bg, cmd_ba;
  logic [AW-1:0] cmd_addr;

  int checks = 0, failures = 0, cyc = 0;

  always #5 CLK = ~CLK;

  dram_cmd_scheduler #(.CNT_W(12), .ADDR_W(AW), .T_RCD(T_RCD), .T_RTP(T_RTP), .T_WTP(T_WTP),
                       .T_RP(T_RP), .T_RFC(T_RFC), .T_REFI(T_REFI)) dut (
    .CLK(CLK), .RST(RST), .init_valid(init_valid), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row), .req_col(req_col),
    .cmd(cmd), .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .busy(busy),
    .ref_overflow(ref_overflow));

`ifdef DRAM_SCHED_REFRESH_EN
  // Short-timing instance so a refresh interval can expire inside one request sequence.
  logic          f_init = 1'b0, f_valid = 1'b0;
  logic          f_ready, f_busy, f_ovf;
  logic [2:0]    f_cmd;
  logic [1:0]    f_bg, f_ba;
  logic [AW-1:0] f_addr;

  dram_cmd_scheduler #(.CNT_W(12), .ADDR_W(AW), .T_RCD(4), .T_RTP(3), .T_WTP(6), .T_RP(4),
                       .T_RFC(5), .T_REFI(8)) dut_fast (
    .CLK(CLK), .RST(RST), .init_valid(f_init), .req_valid(f_valid), .req_ready(f_ready),
    .req_wr(1'b1), .req_bg(2'd3), .req_ba(2'd1), .req_row(17'h00042), .req_col(10'h011),
    .cmd(f_cmd), .cmd_bg(f_bg), .cmd_ba(f_ba), .cmd_addr(f_addr), .busy(f_busy),
    .ref_overflow(f_ovf));
`endif

  // Model: each accepted request/refresh is expanded into absolute command timestamps.
  typedef struct packed {
    logic [2:0]    c;
    logic [1:0]    bg;
    logic [1:0]    ba;
    logic [AW-1:0] a;
  } ecmd_t;

  ecmd_t sched[int];
  bit    inited = 1'b0;
  int    t0 = 0, ready_at = 0, refs_done = 0;

  typedef struct {
    logic          wr;
    logic [1:0]    bg, ba;
    logic [AW-1:0] row;
    logic [9:0]    col;
    int            rw_off, pre_off, rdy_off;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  function automatic bit model_pending(int c);
    if (!REF_EN || !inited || c < t0) return 1'b0;
    return ((c - t0) / T_REFI) > refs_done;
  endfunction

  task automatic compare_all();
    ecmd_t e;
    bit    idle;
    e    = '0;
    idle = inited && (cyc >= ready_at);
    if (sched.exists(cyc)) e = sched[cyc];
    chk("m_cmd",   32'(cmd),      32'(e.c));
    chk("m_bg",    32'(cmd_bg),   32'(e.bg));
    chk("m_ba",    32'(cmd_ba),   32'(e.ba));
    chk("m_addr",  32'(cmd_addr), 32'(e.a));
    chk("m_ready", 32'(req_ready), 32'(idle && !model_pending(cyc)));
    chk("m_busy",  32'(busy),     32'(!idle));
    chk("m_ovf",   32'(ref_overflow), 32'd0);
  endtask

  // Compare the current cycle, drive this cycle's inputs, advance the model, clock.
  task automatic step(input bit iv, input bit v, input bit wr, input logic [1:0] bg,
                      input logic [1:0] ba, input logic [AW-1:0] row, input logic [9:0] col);
    int p;
    compare_all();
    init_valid = iv; req_valid = v; req_wr = wr;
    req_bg = bg; req_ba = ba; req_row = row; req_col = col;
    if (!inited) begin
      if (iv) begin inited = 1'b1; t0 = cyc + 1; ready_at = cyc + 1; end
    end else if (cyc >= ready_at) begin
      if (model_pending(cyc)) begin
        sched[cyc+1] = '{c: 3'd5, default: '0};
        refs_done++;
        ready_at = cyc + 1 + T_RFC;
      end else if (v) begin
        sched[cyc+1] = '{c: 3'd1, bg: bg, ba: ba, a: row};
        sched[cyc+1+T_RCD] = '{c: wr ? 3'd3 : 3'd2, bg: bg, ba: ba, a: AW'(col)};
        p = cyc + 1 + T_RCD + (wr ? T_WTP : T_RTP);
        sched[p] = '{c: 3'd4, bg: bg, ba: ba, a: '0};
        ready_at = p + T_RP;
      end
    end
    tick();
  endtask

  task automatic idle1();
    step(1'b0, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    #1;
    chk("rst_cmd",   32'(cmd),       32'd0);
    chk("rst_addr",  32'(cmd_addr),  32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_busy",  32'(busy),      32'd1);
    chk("rst_ovf",   32'(ref_overflow), 32'd0);
    inited = 1'b0; refs_done = 0; sched.delete();
    tick();
    RST = 1'b0;
  endtask

  task automatic wait_ready(input int lim);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < lim) begin idle1(); n++; end
    if (req_ready !== 1'b1) begin
      checks++; failures++;
      $display("FAIL wait_ready timeout cyc=%0d got=0 exp=1", cyc);
    end
  endtask

  initial begin
    logic [2:0] ec; logic [1:0] eb, ea; logic [AW-1:0] ead;
    bit rv, rw, ri; logic [1:0] rbg, rba; logic [AW-1:0] rrow; logic [9:0] rcol;
    int h, n;

    vt[0] = '{1'b0, 2'd1, 2'd2, 17'h01234, 10'h03F, 17, 25, 41};
    vt[1] = '{1'b1, 2'd3, 2'd0, 17'h1FFFF, 10'h3FF, 17, 41, 57};
    vt[2] = '{1'b0, 2'd0, 2'd3, 17'h00000, 10'h000, 17, 25, 41};
    vt[3] = '{1'b1, 2'd2, 2'd1, 17'h0ABCD, 10'h155, 17, 41, 57};

    #1;
    do_reset();
    cyc = 0;
    for (int i = 0; i < 5; i++) idle1();
    chk("pre_init_ready", 32'(req_ready), 32'd0);
    chk("pre_init_busy",  32'(busy),      32'd1);
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);
    chk("init_ready_c6", 32'(req_ready), 32'd1);

    // Directed table; req_valid stays high through each sequence.
    for (int i = 0; i < 4; i++) begin
      wait_ready(200);
      for (int k = 0; k <= vt[i].rdy_off; k++) begin
        ec = 3'd0; eb = 2'd0; ea = 2'd0; ead = '0;
        if (k == 1) begin ec = 3'd1; eb = vt[i].bg; ea = vt[i].ba; ead = vt[i].row; end
        if (k == vt[i].rw_off) begin
          ec = vt[i].wr ? 3'd3 : 3'd2; eb = vt[i].bg; ea = vt[i].ba; ead = AW'(vt[i].col);
        end
        if (k == vt[i].pre_off) begin ec = 3'd4; eb = vt[i].bg; ea = vt[i].ba; end
        chk("v_cmd",   32'(cmd),      32'(ec));
        chk("v_bg",    32'(cmd_bg),   32'(eb));
        chk("v_ba",    32'(cmd_ba),   32'(ea));
        chk("v_addr",  32'(cmd_addr), 32'(ead));
        chk("v_ready", 32'(req_ready), 32'(k == 0 || k == vt[i].rdy_off));
        if (k < vt[i].rdy_off)
          step(1'b0, 1'b1, vt[i].wr, vt[i].bg, vt[i].ba, vt[i].row, vt[i].col);
      end
    end

    // Reset while waiting out tRCD: sequence abandoned, nothing issued until init_valid again.
    wait_ready(200);
    step(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 17'h01234, 10'h03F);
    chk("rst_seq_act", 32'(cmd), 32'd1);
    for (int i = 0; i < 3; i++) idle1();
    do_reset();
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0, 2'd1, 2'd2, 17'h01234, 10'h03F);
    chk("rst_no_rd", 32'(cmd), 32'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);

    // Randomized traffic, with init_valid toggling to show it is ignored once running.
    for (int i = 0; i < 4000; i++) begin
      ri = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) == 0);
      rw = 1'($urandom_range(0, 1));
      rbg = 2'($urandom); rba = 2'($urandom);
      rrow = AW'($urandom); rcol = 10'($urandom);
      step(ri, rv, rw, rbg, rba, rrow, rcol);
    end

`ifdef DRAM_SCHED_REFRESH_EN
    // Refresh from idle, with a request waiting behind it.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);
    while (cyc < t0 + T_REFI) idle1();
    chk("ref_pend_ready", 32'(req_ready), 32'd0);
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 17'h00777, 10'h021);
    chk("ref_cmd",  32'(cmd),      32'd5);
    chk("ref_addr", 32'(cmd_addr), 32'd0);
    n = 0;
    while (req_ready !== 1'b1 && n < T_RFC + 10) begin
      step(1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 17'h00777, 10'h021); n++;
    end
    chk("ref_rfc_len", 32'(cyc), 32'(t0 + T_REFI + 1 + T_RFC));
    step(1'b0, 1'b1, 1'b0, 2'd2, 2'd3, 17'h00777, 10'h021);
    chk("ref_then_act", 32'(cmd), 32'd1);
    for (int i = 0; i < 50; i++) idle1();

    // Request in the same cycle the interval expires: request first, then REF.
    do_reset();
    step(1'b1, 1'b0, 1'b0, 2'd0, 2'd0, '0, '0);
    while (cyc < t0 + T_REFI - 1) idle1();
    chk("coll_ready", 32'(req_ready), 32'd1);
    h = cyc;
    step(1'b0, 1'b1, 1'b0, 2'd1, 2'd1, 17'h00055, 10'h00A);
    for (int k = 1; k <= 42; k++) begin
      case (k)
        1:  chk("coll_act", 32'(cmd), 32'd1);
        17: chk("coll_rd",  32'(cmd), 32'd2);
        25: chk("coll_pre", 32'(cmd), 32'd4);
        41: chk("coll_idle_pend", 32'(req_ready), 32'd0);
        42: chk("coll_ref", 32'(cmd), 32'd5);
        default: ;
      endcase
      chk("coll_cyc", 32'(cyc), 32'(h + k));
      idle1();
    end

    // Overflow on the short-timing instance: a write sequence spans two refresh intervals.
    do_reset();
    f_init = 1'b1;
    tick();
    f_init = 1'b0;
    for (int k = 0; k <= 30; k++) begin
      case (k)
        0:  chk("f_ready", 32'(f_ready), 32'd1);
        1:  chk("f_act",   32'(f_cmd),   32'd1);
        5:  chk("f_wr",    32'(f_cmd),   32'd3);
        11: chk("f_pre",   32'(f_cmd),   32'd4);
        14: chk("f_ovf_lo", 32'(f_ovf),  32'd0);
        16: begin
          chk("f_ref",     32'(f_cmd), 32'd5);
          chk("f_ovf_set", 32'(f_ovf), 32'd1);
        end
        30: chk("f_ovf_sticky", 32'(f_ovf), 32'd1);
        default: ;
      endcase
      f_valid = (k == 0);
      tick();
    end
    f_valid = 1'b0;
    RST = 1'b1;
    #1;
    chk("f_ovf_rst", 32'(f_ovf), 32'd0);
    RST = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
